// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered fill level, threshold
// flags, error pulses and a selectable first-word-fall-through read port.
module sync_fifo_param #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int ADDR_WIDTH    = $clog2(DEPTH),
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  wr_valid_i,
  input  logic                  rd_valid_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  rdata_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  wr_error_o,
  output logic                  rd_error_o
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LP_AF    = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] LP_AE    = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [ADDR_WIDTH:0] r_wr_ptr;
  logic [ADDR_WIDTH:0] r_rd_ptr;
  logic [ADDR_WIDTH:0] r_count;
  logic                r_full;
  logic                r_empty;
  logic                r_afull;
  logic                r_aempty;
  logic                r_wr_err;
  logic                r_rd_err;

  logic                w_wr_en;
  logic                w_rd_en;
  logic [ADDR_WIDTH:0] w_wr_ptr_nxt;
  logic [ADDR_WIDTH:0] w_rd_ptr_nxt;
  logic [ADDR_WIDTH:0] w_count_nxt;

  // Acceptance uses the registered flags only; no pass-through at full.
  assign w_wr_en      = wr_valid_i && !r_full;
  assign w_rd_en      = rd_valid_i && !r_empty;
  assign w_wr_ptr_nxt = r_wr_ptr + (ADDR_WIDTH+1)'(w_wr_en);
  assign w_rd_ptr_nxt = r_rd_ptr + (ADDR_WIDTH+1)'(w_rd_en);
  assign w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_wr_err <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == LP_DEPTH);
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (w_count_nxt >= LP_AF);
      r_aempty <= (w_count_nxt <= LP_AE);
      r_wr_err <= wr_valid_i && r_full;
      r_rd_err <= rd_valid_i && r_empty;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wdata_i;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata_o       = r_empty ? '0 : r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
      assign rdata_valid_o = 1'b0;
    end else begin : g_std
      logic [WIDTH-1:0] r_rdata;
      logic             r_rvalid;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_rdata  <= '0;
          r_rvalid <= 1'b0;
        end else begin
          r_rvalid <= w_rd_en;
          if (w_rd_en) begin
            r_rdata <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
          end
        end
      end

      assign rdata_o       = r_rdata;
      assign rdata_valid_o = r_rvalid;
    end
  endgenerate

  assign full_o         = r_full;
  assign empty_o        = r_empty;
  assign almost_full_o  = r_afull;
  assign almost_empty_o = r_aempty;
  assign count_o        = r_count;
  assign wr_error_o     = r_wr_err;
  assign rd_error_o     = r_rd_err;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param, standard and FWFT
// instances driven in lockstep against a queue-based reference.
module tb_sync_fifo_param;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] wdata;
  logic         wr_valid;
  logic         rd_valid;

  logic [W-1:0] s_rdata, f_rdata;
  logic         s_rv, f_rv;
  logic         s_full, f_full, s_empty, f_empty;
  logic         s_af, f_af, s_ae, f_ae;
  logic [AW:0]  s_cnt, f_cnt;
  logic         s_werr, f_werr, s_rerr, f_rerr;

  int n_checks;
  int n_fail;

  logic [W-1:0] q[$];
  logic [W-1:0] e_rdata;
  logic         e_rv;
  logic         e_werr;
  logic         e_rerr;

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
    .clk_i(clk), .rst_i(rst), .wdata_i(wdata),
    .wr_valid_i(wr_valid), .rd_valid_i(rd_valid),
    .rdata_o(s_rdata), .rdata_valid_o(s_rv),
    .full_o(s_full), .empty_o(s_empty),
    .almost_full_o(s_af), .almost_empty_o(s_ae),
    .count_o(s_cnt), .wr_error_o(s_werr), .rd_error_o(s_rerr)
  );

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
    .clk_i(clk), .rst_i(rst), .wdata_i(wdata),
    .wr_valid_i(wr_valid), .rd_valid_i(rd_valid),
    .rdata_o(f_rdata), .rdata_valid_o(f_rv),
    .full_o(f_full), .empty_o(f_empty),
    .almost_full_o(f_af), .almost_empty_o(f_ae),
    .count_o(f_cnt), .wr_error_o(f_werr), .rd_error_o(f_rerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("s_count", 32'(s_cnt), 32'(n));
    check("f_count", 32'(f_cnt), 32'(n));
    check("s_full", 32'(s_full), 32'(n == D));
    check("f_full", 32'(f_full), 32'(n == D));
    check("s_empty", 32'(s_empty), 32'(n == 0));
    check("f_empty", 32'(f_empty), 32'(n == 0));
    check("s_afull", 32'(s_af), 32'(n >= D - 2));
    check("f_afull", 32'(f_af), 32'(n >= D - 2));
    check("s_aempty", 32'(s_ae), 32'(n <= 2));
    check("f_aempty", 32'(f_ae), 32'(n <= 2));
    check("s_wr_err", 32'(s_werr), 32'(e_werr));
    check("f_wr_err", 32'(f_werr), 32'(e_werr));
    check("s_rd_err", 32'(s_rerr), 32'(e_rerr));
    check("f_rd_err", 32'(f_rerr), 32'(e_rerr));
    check("s_rdata", 32'(s_rdata), 32'(e_rdata));
    check("s_rvalid", 32'(s_rv), 32'(e_rv));
    check("f_rdata", 32'(f_rdata), (n == 0) ? 32'h0 : 32'(q[0]));
    check("f_rvalid", 32'(f_rv), 32'h0);
  endtask

  task automatic model_reset();
    q.delete();
    e_rdata = '0;
    e_rv    = 1'b0;
    e_werr  = 1'b0;
    e_rerr  = 1'b0;
  endtask

  task automatic step(input logic wr, input logic rd, input logic [W-1:0] d);
    int n;
    wr_valid = wr;
    rd_valid = rd;
    wdata    = d;
    @(posedge clk);
    #1;
    n      = q.size();
    e_werr = wr && (n == D);
    e_rerr = rd && (n == 0);
    e_rv   = 1'b0;
    if (rd && n > 0) begin
      e_rdata = q.pop_front();
      e_rv    = 1'b1;
    end
    if (wr && n < D) q.push_back(d);
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    check_all();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    wdata    = '0;
    rst      = 1'b1;
    model_reset();
    #12;
    check_all();
    rst = 1'b0;

    for (int i = 0; i < D; i++) step(1'b1, 1'b0, W'(i));
    step(1'b1, 1'b0, 8'hAA);
    step(1'b1, 1'b1, 8'hAB);
    check("full_rw_cnt", 32'(s_cnt), 32'd15);
    while (q.size() > 0) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 8'h77);
    check("empty_rw_err", 32'(s_rerr), 32'd1);
    step(1'b0, 1'b1, '0);

    step(1'b1, 1'b0, 8'h5A);
    check("fwft_5a", 32'(f_rdata), 32'h5A);
    step(1'b0, 1'b1, '0);
    check("fwft_pop0", 32'(f_rdata), 32'h0);

    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, W'($urandom));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, W'($urandom));
    check("steady_cnt", 32'(s_cnt), 32'd8);

    for (int i = 0; i < 500; i++) begin
      int bias;
      bias = (i / 100) % 3;
      step(($urandom_range(0, 9) < 3 + 2 * bias) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 7 - 2 * bias) ? 1'b1 : 1'b0,
           W'($urandom));
    end

    while (q.size() > 9) step(1'b0, 1'b1, '0);
    while (q.size() < 9) step(1'b1, 1'b0, W'($urandom));
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #2;
    check_all();
    rst = 1'b0;

    step(1'b1, 1'b0, 8'h33);
    step(1'b0, 1'b1, '0);
    check("after_rst_33", 32'(s_rdata), 32'h33);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: the next-generation buffering block for same-domain data paths. It generalises data width and depth and adds a registered fill level, programmable almost-full/almost-empty thresholds, and a selectable first-word-fall-through (FWFT) read mode. It also adds registered per-cycle overflow/underflow error pulses. It sits between a producer and a consumer on the same clock, typically in front of or behind an asynchronous FIFO.

## Interface
- WIDTH, 8: data word width in bits, ≥1
- DEPTH, 16: number of entries; power of two, ≥4
- ADDR_WIDTH, $clog2(DEPTH): memory address width (derived, do not override)
- AFULL_THRESH, DEPTH-2: almost_full_o asserts when count ≥ AFULL_THRESH; range 1..DEPTH
- AEMPTY_THRESH, 2: almost_empty_o asserts when count ≤ AEMPTY_THRESH; range 0..DEPTH-1
- FWFT, 0: 0 = standard registered read, 1 = first-word-fall-through

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- wdata_i  in  WIDTH  write data
- wr_valid_i  in  1  write request
- rd_valid_i  in  1  read request
- rdata_o  out  WIDTH  read data
- rdata_valid_o  out  1  rdata_o updated this cycle; standard mode only, tied 0 when FWFT=1
- full_o  out  1  count == DEPTH
- empty_o  out  1  count == 0
- almost_full_o  out  1  count ≥ AFULL_THRESH
- almost_empty_o  out  1  count ≤ AEMPTY_THRESH
- count_o  out  ADDR_WIDTH+1  current fill level, 0..DEPTH
- wr_error_o  out  1  one-cycle pulse: write rejected
- rd_error_o  out  1  one-cycle pulse: read rejected

## Operation
- Pointers wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide. The low ADDR_WIDTH bits address memory; the MSB is the wrap bit.
- count = wr_ptr − rd_ptr, modulo 2^(ADDR_WIDTH+1).
- Write acceptance: wr_valid_i && !full_o, where full_o is the registered value. On an accepted write, memory[wr_ptr] ← wdata_i and wr_ptr increments.
- Read acceptance: rd_valid_i && !empty_o, where empty_o is the registered value. On an accepted read, rd_ptr increments.
- A write is rejected only when full_o is high; a read is rejected only when empty_o is high. There is no same-cycle pass-through: a write when full is rejected even if a read is also accepted that cycle.
- Rejected write: wr_error_o = 1 next cycle. Memory, pointers and count are unchanged.
- Rejected read: rd_error_o = 1 next cycle. rdata_o holds, and rdata_valid_o stays 0.
- Simultaneous accepted write and read: both pointers advance and count is unchanged.
- Pointer wrap: incrementing the low bits from DEPTH−1 wraps them to 0 and toggles the MSB.
- Flags and count are registered and recomputed from next-state pointers on every edge, so they are always consistent with each other.
- Standard mode (FWFT=0):
  - On an accepted read, rdata_o ← memory[rd_ptr] at that edge and rdata_valid_o = 1 for one cycle.
  - Otherwise rdata_o holds and rdata_valid_o = 0.
- FWFT mode (FWFT=1):
  - rdata_o = memory[rd_ptr[ADDR_WIDTH-1:0]] continuously whenever empty_o = 0.
  - rdata_o is 0 when empty_o = 1.
  - An accepted read pops the head, and the next entry appears after the edge.
- Reset (asynchronous, any time, including mid-transfer):
  - Pointers and count_o = 0, empty_o = 1, full_o = 0, almost_empty_o = 1, almost_full_o = 0.
  - rdata_o = 0, rdata_valid_o = 0, wr_error_o = 0, rd_error_o = 0.
  - Memory contents are not cleared.
  - Operation resumes on the first rising clk_i edge after rst_i deasserts.

## Timing
- Write accepted at edge t: count_o, empty_o and the almost flags reflect it from t onward, visible in cycle t+1. The earliest read of that word is at edge t+1.
- Standard mode read latency: rd_valid_i sampled at edge t, data on rdata_o after edge t, with rdata_valid_o high for that one cycle.
- FWFT mode: data is present in the same cycle that empty_o is low, so read latency is 0.
- Throughput: one write and one read per cycle, sustained, when neither full nor empty.
- Error pulses last exactly one cycle per rejected request. Back-to-back rejected requests hold the pulse high continuously.

## Test plan
- Reset/fill/drain (DEPTH=16, WIDTH=8, FWFT=0):
  - After reset: count_o=0, empty_o=1, almost_empty_o=1.
  - Write 0x00..0x0F on 16 consecutive cycles → full_o=1, count_o=16, almost_full_o asserted from count 14.
  - Read 16 → rdata_o sequence 0x00..0x0F with rdata_valid_o high each cycle, then empty_o=1.
- Overflow/underflow:
  - At full, write 0xAA → wr_error_o high one cycle, count_o stays 16, and the next 16 reads contain no 0xAA.
  - At empty, read → rd_error_o high one cycle and rdata_o unchanged.
- Simultaneous read/write:
  - At count 8, assert both for 20 cycles → count_o stays 8 and output order is preserved.
  - Pointers wrap at least once, with no error pulses.
- Boundaries:
  - At full, read and write in the same cycle → read accepted, write rejected, count_o=15.
  - At empty, read and write in the same cycle → write accepted, rd_error_o=1, count_o=1.
- FWFT=1:
  - Write 0x5A to an empty FIFO → next cycle empty_o=0 and rdata_o=0x5A without any read.
  - Read → empty_o=1 and rdata_o=0.
- Asynchronous reset mid-operation:
  - Assert rst_i between edges at count 9 → all outputs reach reset values immediately, without waiting for a clock edge.
  - After release, a write of 0x33 followed by a read returns 0x33.
